// File: rtl/stop_watch_lap_if.sv
// Stopwatch control/status bundle.
//   Host -> stopwatch : start_resume, stop, clear, lap, lap_rd (one-cycle pulses)
//   Stopwatch -> host : BCD time digits (MM:SS.hh), running, overflow,
//                       lap FIFO head (lap_data) and status (lap_valid,
//                       lap_full, lap_count).
// LAP_DEPTH must match the stopwatch instance; it sizes lap_count.
interface stop_watch_lap_if #(
    parameter int LAP_DEPTH = 4
);
    localparam int CW = $clog2(LAP_DEPTH + 1);

    logic          start_resume;
    logic          stop;
    logic          clear;
    logic          lap;
    logic          lap_rd;

    logic [3:0]    min1;
    logic [3:0]    min0;
    logic [3:0]    sec1;
    logic [3:0]    sec0;
    logic [3:0]    milSec1;
    logic [3:0]    milSec0;
    logic          running;
    logic          overflow;
    logic [23:0]   lap_data;
    logic          lap_valid;
    logic          lap_full;
    logic [CW-1:0] lap_count;

    // Host side.
    modport master (
        output start_resume, stop, clear, lap, lap_rd,
        input  min1, min0, sec1, sec0, milSec1, milSec0,
        input  running, overflow, lap_data, lap_valid, lap_full, lap_count
    );

    // Stopwatch side.
    modport slave (
        input  start_resume, stop, clear, lap, lap_rd,
        output min1, min0, sec1, sec0, milSec1, milSec0,
        output running, overflow, lap_data, lap_valid, lap_full, lap_count
    );
endinterface

// File: rtl/stop_watch_lap.sv
// Stopwatch with MM:SS.hh BCD display and a lap-time FIFO.
//   clk   : single clock, all state changes on its rising edge
//   reset : asynchronous, active-high; returns to IDLE with everything zeroed
//   bus   : stop_watch_lap_if.slave (control pulses in, time/lap status out)
// Parameters:
//   TICK_DIV  : clk cycles per 1/100 s tick (>= 1)
//   LAP_DEPTH : lap FIFO entries (>= 1)
//   WRAP      : 0 = saturate at 59:59.99 and pause, 1 = roll over to 00:00.00
module stop_watch_lap #(
    parameter int TICK_DIV  = 100000,
    parameter int LAP_DEPTH = 4,
    parameter bit WRAP      = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    stop_watch_lap_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int CW = $clog2(LAP_DEPTH + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // Also serves as the per-digit roll-over limit table of the BCD cascade.
    localparam logic [23:0]   TIME_MAX   = 24'h595999;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   time_q, time_d;       // {min1,min0,sec1,sec0,milSec1,milSec0}
    logic          overflow_q, overflow_d;

    logic [23:0]   lap_mem [LAP_DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic resume_req;
    logic tick;
    logic at_max;
    logic clear_act;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;

    // Add one hundredth to a BCD time; each digit that hits its limit rolls to
    // zero and carries into the next one within the same cycle.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        carry;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == TIME_MAX[i*4 +: 4]) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(LAP_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Stop overrides start_resume in every state.
    assign resume_req = bus.start_resume && !bus.stop;
    assign tick       = (state_q == RUN) && (presc_q == PRESC_LAST);
    assign at_max     = (time_q == TIME_MAX);
    // In PAUSE a valid resume takes precedence over clear.
    assign clear_act  = (state_q == PAUSE) && bus.clear && !resume_req;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(LAP_DEPTH));
    assign pop        = bus.lap_rd && !fifo_empty;
    // A full FIFO still accepts a lap when the same cycle frees the head slot.
    assign push       = bus.lap && (state_q != IDLE) && (!fifo_full || pop);

    // Next-state for FSM, prescaler, time digits and overflow flag.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no
        // path can leave one unassigned and infer a latch.
        state_d    = state_q;
        presc_d    = presc_q;
        time_d     = time_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE:    if (resume_req) state_d = RUN;
            RUN:     if (bus.stop) state_d = PAUSE;
            PAUSE: begin
                if (resume_req) begin
                    state_d = RUN;
                end else if (bus.clear) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Counts only in RUN; PAUSE keeps the partial tick for the resume.
        if (state_q == RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (tick) begin
            if (at_max) begin
                overflow_d = 1'b1;
                if (WRAP) begin
                    time_d = '0;
                end else begin
                    state_d = PAUSE;
                end
            end else begin
                time_d = bcd_inc(time_q);
            end
        end

        if (clear_act) begin
            presc_d    = '0;
            time_d     = '0;
            overflow_d = 1'b0;
        end
    end

    // Next-state for the lap FIFO pointers and occupancy.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_act) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            time_q     <= '0;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            time_q     <= time_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: the lap storage has no reset; lap_data is masked by the entry
    // count, so stale words are never visible after reset or clear.
    always_ff @(posedge clk) begin
        if (push && !clear_act) begin
            lap_mem[wr_ptr_q] <= time_q;  // time before this cycle's update
        end
    end

    assign {bus.min1, bus.min0, bus.sec1, bus.sec0, bus.milSec1, bus.milSec0} = time_q;
    assign bus.running   = (state_q == RUN);
    assign bus.overflow  = overflow_q;
    assign bus.lap_data  = fifo_empty ? '0 : lap_mem[rd_ptr_q];
    assign bus.lap_valid = !fifo_empty;
    assign bus.lap_full  = fifo_full;
    assign bus.lap_count = count_q;
endmodule

// File: tb/tb_stop_watch_lap.sv
// Self-checking bench for stop_watch_lap.
// Two instances share stimulus: dut0 saturates (WRAP=0), dut1 wraps (WRAP=1).
// Directed vector table, hand-written overflow / async-reset sequences and a
// randomized run against a centisecond-integer + queue reference model.
module tb_stop_watch_lap;
    localparam int TICK_DIV  = 2;
    localparam int LAP_DEPTH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stop_watch_lap_if #(.LAP_DEPTH(LAP_DEPTH)) if0 ();
    stop_watch_lap_if #(.LAP_DEPTH(LAP_DEPTH)) if1 ();

    stop_watch_lap #(.TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .WRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    stop_watch_lap #(.TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .WRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    assign if1.start_resume = if0.start_resume;
    assign if1.stop         = if0.stop;
    assign if1.clear        = if0.clear;
    assign if1.lap          = if0.lap;
    assign if1.lap_rd       = if0.lap_rd;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] digits0();
        return {if0.min1, if0.min0, if0.sec1, if0.sec0, if0.milSec1, if0.milSec0};
    endfunction

    function automatic logic [23:0] digits1();
        return {if1.min1, if1.min0, if1.sec1, if1.sec0, if1.milSec1, if1.milSec0};
    endfunction

    task automatic drive(input bit sr, input bit st, input bit cl, input bit lp, input bit rd);
        if0.start_resume = sr;
        if0.stop         = st;
        if0.clear        = cl;
        if0.lap          = lp;
        if0.lap_rd       = rd;
    endtask

    // All sequencing helpers start and end at a falling edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pulse(input bit sr, input bit st, input bit cl, input bit lp, input bit rd);
        drive(sr, st, cl, lp, rd);
        cyc(1);
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- reference model (time kept in centiseconds) ----------
    typedef enum int {M_IDLE, M_RUN, M_PAUSE} mstate_e;
    mstate_e     m_st;
    int          m_pc;
    int          m_cs;
    bit          m_ovf;
    logic [23:0] m_q[$];

    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, hh;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        hh = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(hh / 10), 4'(hh % 10)};
    endfunction

    task automatic model_reset();
        m_st  = M_IDLE;
        m_pc  = 0;
        m_cs  = 0;
        m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_step(input bit sr, input bit st, input bit cl, input bit lp, input bit rd);
        bit          resume, tick, pop, push;
        mstate_e     ns;
        logic [23:0] snap;
        resume = sr && !st;
        tick   = (m_st == M_RUN) && (m_pc == TICK_DIV - 1);
        if (m_st == M_PAUSE && cl && !resume) begin
            model_reset();
            return;
        end
        snap = to_bcd(m_cs);
        pop  = rd && (m_q.size() > 0);
        push = lp && (m_st != M_IDLE) && ((m_q.size() < LAP_DEPTH) || pop);
        if (pop)  void'(m_q.pop_front());
        if (push) m_q.push_back(snap);
        ns = m_st;
        if (m_st == M_IDLE && resume) ns = M_RUN;
        if (m_st == M_RUN && st)      ns = M_PAUSE;
        if (m_st == M_PAUSE && resume) ns = M_RUN;
        if (m_st == M_RUN) m_pc = tick ? 0 : m_pc + 1;
        if (tick) begin
            if (m_cs == 59 * 6000 + 5999) begin
                m_ovf = 1;
                ns    = M_PAUSE;  // the WRAP=0 instance is the modelled one
            end else begin
                m_cs++;
            end
        end
        m_st = ns;
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        bit          rst;
        bit          sr, st, cl, lp, rd;
        int          cycles;
        logic [23:0] digits;
        bit          running;
        int          cnt;
        logic [23:0] head;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit sr, input bit st, input bit cl,
                                input bit lp, input bit rd, input int cycles,
                                input logic [23:0] digits, input bit running,
                                input int cnt, input logic [23:0] head);
        vec_t v;
        v.rst = rst; v.sr = sr; v.st = st; v.cl = cl; v.lp = lp; v.rd = rd;
        v.cycles = cycles; v.digits = digits; v.running = running;
        v.cnt = cnt; v.head = head;
        vecs.push_back(v);
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0);

        // Reset state.
        do_reset();
        check("reset_digits", digits0(), 24'h0);
        check("reset_running", if0.running, 1'b0);
        check("reset_valid", if0.lap_valid, 1'b0);

        //    rst sr st cl lp rd cyc  digits     run cnt head
        add(1, 1, 0, 0, 0, 0,   1, 24'h000000, 1, 0, 24'h0);
        add(0, 0, 0, 0, 0, 0, 200, 24'h000100, 1, 0, 24'h0);  // 100 ticks = 1 s
        add(0, 0, 1, 0, 0, 0,   1, 24'h000100, 0, 0, 24'h0);
        add(0, 0, 0, 0, 0, 0,  20, 24'h000100, 0, 0, 24'h0);
        add(0, 1, 0, 0, 0, 0,   1, 24'h000100, 1, 0, 24'h0);
        add(0, 0, 0, 0, 0, 0,   1, 24'h000101, 1, 0, 24'h0);  // partial tick completes
        add(0, 0, 0, 0, 0, 0,   9, 24'h000105, 1, 0, 24'h0);
        add(0, 1, 1, 0, 0, 0,   1, 24'h000106, 0, 0, 24'h0);  // stop wins in RUN
        add(0, 1, 1, 0, 0, 0,   1, 24'h000106, 0, 0, 24'h0);  // stop wins in PAUSE
        add(0, 0, 0, 1, 0, 0,   1, 24'h000000, 0, 0, 24'h0);
        add(0, 1, 1, 0, 0, 0,   1, 24'h000000, 0, 0, 24'h0);  // stop wins in IDLE
        add(0, 1, 0, 0, 0, 0,   1, 24'h000000, 1, 0, 24'h0);
        add(0, 0, 0, 1, 0, 0,   3, 24'h000001, 1, 0, 24'h0);  // clear in RUN ignored
        // Lap FIFO.
        add(1, 1, 0, 0, 0, 0,   1, 24'h000000, 1, 0, 24'h0);
        add(0, 0, 0, 0, 0, 0,   2, 24'h000001, 1, 0, 24'h0);
        add(0, 0, 0, 0, 1, 0,   2, 24'h000002, 1, 1, 24'h000001);
        add(0, 0, 0, 0, 1, 0,   2, 24'h000003, 1, 2, 24'h000001);
        add(0, 0, 0, 0, 1, 0,   2, 24'h000004, 1, 3, 24'h000001);
        add(0, 0, 0, 0, 1, 0,   2, 24'h000005, 1, 4, 24'h000001);
        add(0, 0, 0, 0, 1, 0,   2, 24'h000006, 1, 4, 24'h000001);  // dropped
        add(0, 0, 0, 0, 1, 1,   2, 24'h000007, 1, 4, 24'h000002);  // push+pop while full
        add(0, 0, 0, 0, 0, 1,   1, 24'h000007, 1, 3, 24'h000003);
        add(0, 0, 0, 0, 0, 1,   1, 24'h000008, 1, 2, 24'h000004);
        add(0, 0, 0, 0, 0, 1,   1, 24'h000008, 1, 1, 24'h000006);
        add(0, 0, 0, 0, 0, 1,   1, 24'h000009, 1, 0, 24'h000000);
        add(0, 0, 0, 0, 0, 1,   1, 24'h000009, 1, 0, 24'h000000);  // pop when empty
        add(0, 0, 1, 0, 0, 0,   1, 24'h000010, 0, 0, 24'h000000);
        add(0, 0, 0, 0, 1, 0,   1, 24'h000010, 0, 1, 24'h000010);  // lap in PAUSE
        add(0, 0, 0, 1, 0, 0,   1, 24'h000000, 0, 0, 24'h000000);  // clear in PAUSE
        add(0, 0, 0, 0, 1, 0,   1, 24'h000000, 0, 0, 24'h000000);  // lap in IDLE

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].sr, vecs[i].st, vecs[i].cl, vecs[i].lp, vecs[i].rd);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (c == 0) drive(0, 0, 0, 0, 0);
            end
            check($sformatf("vec%0d_digits", i), digits0(), vecs[i].digits);
            check($sformatf("vec%0d_running", i), if0.running, vecs[i].running);
            check($sformatf("vec%0d_overflow", i), if0.overflow, 1'b0);
            check($sformatf("vec%0d_count", i), if0.lap_count, vecs[i].cnt);
            check($sformatf("vec%0d_head", i), if0.lap_data, vecs[i].head);
            check($sformatf("vec%0d_valid", i), if0.lap_valid, vecs[i].cnt != 0);
            check($sformatf("vec%0d_full", i), if0.lap_full, vecs[i].cnt == LAP_DEPTH);
        end

        // Carry cascade and end-of-range behaviour, starting from preloaded times.
        do_reset();
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        force dut0.time_q = 24'h095999;
        cyc(1);
        release dut0.time_q;
        check("casc_pre", digits0(), 24'h095999);
        pulse(1, 0, 0, 0, 0);
        cyc(1);
        check("casc_carry", digits0(), 24'h100000);
        pulse(0, 1, 0, 0, 0);
        force dut0.time_q = 24'h595998;
        force dut1.time_q = 24'h595998;
        cyc(1);
        release dut0.time_q;
        release dut1.time_q;
        pulse(1, 0, 0, 0, 0);
        cyc(1);
        check("max0_digits", digits0(), 24'h595999);
        check("max1_digits", digits1(), 24'h595999);
        check("max0_overflow", if0.overflow, 1'b0);
        cyc(2);
        check("sat_digits", digits0(), 24'h595999);
        check("sat_overflow", if0.overflow, 1'b1);
        check("sat_running", if0.running, 1'b0);
        check("wrap_digits", digits1(), 24'h000000);
        check("wrap_overflow", if1.overflow, 1'b1);
        check("wrap_running", if1.running, 1'b1);
        pulse(1, 0, 0, 0, 0);
        cyc(1);
        check("sat_resumed", if0.running, 1'b1);
        check("wrap_counting", digits1(), 24'h000001);
        cyc(1);
        check("sat_again_digits", digits0(), 24'h595999);
        check("sat_again_running", if0.running, 1'b0);
        check("wrap_ovf_sticky", if1.overflow, 1'b1);
        pulse(0, 0, 1, 0, 0);
        check("sat_clear_digits", digits0(), 24'h0);
        check("sat_clear_overflow", if0.overflow, 1'b0);
        check("wrap_clear_ignored", if1.overflow, 1'b1);
        check("wrap_clear_running", if1.running, 1'b1);

        // Asynchronous reset in the middle of running with a lap being taken.
        do_reset();
        pulse(1, 0, 0, 0, 0);
        cyc(10);
        pulse(0, 0, 0, 1, 0);
        check("ar_pre_head", if0.lap_data, 24'h000005);
        check("ar_pre_count", if0.lap_count, 1);
        if0.lap = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_digits", digits0(), 24'h0);
        check("ar_running", if0.running, 1'b0);
        check("ar_count", if0.lap_count, 0);
        check("ar_valid", if0.lap_valid, 1'b0);
        check("ar_full", if0.lap_full, 1'b0);
        check("ar_data", if0.lap_data, 24'h0);
        check("ar_overflow", if0.overflow, 1'b0);
        if0.lap = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cyc(10);
        check("ar_idle_running", if0.running, 1'b0);
        check("ar_idle_digits", digits0(), 24'h0);
        check("ar_idle_count", if0.lap_count, 0);
        pulse(1, 0, 0, 0, 0);
        check("ar_restart", if0.running, 1'b1);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit sr, st, cl, lp, rd;
            sr = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 15) == 0);
            cl = ($urandom_range(0, 11) == 0);
            lp = ($urandom_range(0, 5) == 0);
            rd = ($urandom_range(0, 5) == 0);
            drive(sr, st, cl, lp, rd);
            model_step(sr, st, cl, lp, rd);
            cyc(1);
            check("rnd_digits", digits0(), to_bcd(m_cs));
            check("rnd_running", if0.running, m_st == M_RUN);
            check("rnd_overflow", if0.overflow, m_ovf);
            check("rnd_count", if0.lap_count, m_q.size());
            check("rnd_head", if0.lap_data, (m_q.size() > 0) ? m_q[0] : 24'h0);
        end
        drive(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stop_watch_lap.md
STOP_WATCH_LAP -- requirements
Module: stop_watch_lap

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000: clk cycles per 1/100 s tick (>=1).
REQ-002 The block SHALL have parameter LAP_DEPTH, default 4: lap FIFO entries (>=1).
REQ-003 The block SHALL have parameter WRAP, default 0: 0 = saturate at 59:59.99 and pause; 1 = wrap to 00:00.00 and keep running.
REQ-004 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port start_resume  input  1  one-cycle pulse; starts or resumes counting.
REQ-007 The block SHALL have port stop  input  1  one-cycle pulse; pauses counting.
REQ-008 The block SHALL have port clear  input  1  one-cycle pulse; returns the block to idle from PAUSE only.
REQ-009 The block SHALL have port lap  input  1  one-cycle pulse; captures the current time into the lap FIFO.
REQ-010 The block SHALL have port lap_rd  input  1  one-cycle pulse; pops the FIFO head.
REQ-011 The block SHALL have ports min1, min0, sec1, sec0, milSec1, milSec0  output  4 each  BCD time digits (MM:SS.hh).
REQ-012 The block SHALL have port running  output  1  high in state RUN.
REQ-013 The block SHALL have port overflow  output  1  sticky flag: count passed 59:59.99.
REQ-014 The block SHALL have port lap_data  output  24  FIFO head as {min1,min0,sec1,sec0,milSec1,milSec0}.
REQ-015 The block SHALL have port lap_valid  output  1  FIFO not empty.
REQ-016 The block SHALL have port lap_full  output  1  FIFO holds LAP_DEPTH entries.
REQ-017 The block SHALL have port lap_count  output  $clog2(LAP_DEPTH+1)  number of stored entries.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, PAUSE; transitions: IDLE+start_resume->RUN; RUN+stop->PAUSE; PAUSE+start_resume->RUN; PAUSE+clear->IDLE; all other inputs leave the state unchanged.
REQ-019 If start_resume and stop are high in the same cycle, stop SHALL win: RUN->PAUSE, IDLE stays IDLE, PAUSE stays PAUSE.
REQ-020 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, emit tick when it equals TICK_DIV-1, then return to 0; in PAUSE it SHALL hold its value, so a resume completes the partial tick.
REQ-021 On tick, digits SHALL increment as a BCD cascade: milSec0 0-9, milSec1 0-9, sec0 0-9, sec1 0-5, min0 0-9, min1 0-5; each carry propagates in the same cycle, and the updated digits are visible the cycle after the tick.
REQ-022 A tick at 59:59.99 with WRAP=0 SHALL hold the digits, set overflow, and force RUN->PAUSE.
REQ-023 A tick at 59:59.99 with WRAP=1 SHALL load 00:00.00, set overflow, and remain in RUN.
REQ-024 clear in PAUSE SHALL zero all digits, the prescaler, overflow and the lap FIFO in one cycle; clear in IDLE or RUN SHALL be ignored.
REQ-025 lap in RUN or PAUSE SHALL push the digit values present before that cycle's update; lap in IDLE SHALL be ignored; lap when full SHALL be dropped with FIFO contents unchanged.
REQ-026 lap_rd SHALL pop when lap_valid=1 and SHALL be ignored when empty.
REQ-027 lap_data SHALL show the head (show-ahead), reading 0 when empty; a push into an empty FIFO SHALL appear on lap_data the next cycle.
REQ-028 Simultaneous lap and lap_rd with FIFO non-empty SHALL push and pop (lap_count unchanged, including when full); with FIFO empty, only the push SHALL occur.
REQ-029 lap_full SHALL equal (lap_count==LAP_DEPTH) and lap_valid SHALL equal (lap_count!=0), both registered-consistent with lap_count.

Reset
REQ-030 reset high SHALL immediately, without a clock edge, force IDLE, prescaler 0, all digits 0, overflow 0, running 0, FIFO empty (lap_count 0, lap_valid 0, lap_full 0, lap_data 0).
REQ-031 reset asserted mid-RUN or mid-lap SHALL abort the operation; no partial push shall remain after reset deasserts.

Verification
REQ-032 TICK_DIV=2: reset, start_resume, 200 cycles -> digits 00:01.00, running=1.
REQ-033 Run to 00:00.05, stop, 20 idle cycles, start_resume -> count resumes from 00:00.05 without a skip; stop+start_resume in the same cycle -> PAUSE.
REQ-034 WRAP=0, preload path by running to 59:59.99, one more tick -> digits hold 59:59.99, overflow=1, running=0; WRAP=1 -> 00:00.00, overflow=1, running=1.
REQ-035 LAP_DEPTH=4: 5 lap pulses at distinct times -> lap_count=4, lap_full=1, fifth dropped; 4 lap_rd pops return the first four times in order, then lap_valid=0, lap_data=0.
REQ-036 lap and lap_rd in the same cycle while full -> lap_count stays 4, head advances; clear in RUN ignored, clear in PAUSE -> all zero, FIFO empty.
REQ-037 Assert reset asynchronously mid-RUN between clock edges -> outputs zero before the next edge; after release, the block stays IDLE until start_resume.
